// File: rtl/ntp_clock_select.sv
// rtl/ntp_clock_select.sv - Qualifies two NTP clock sources and forwards the selected one's time
//
// Ports:
//   clk, reset                  block clock, synchronous active-high reset
//   cfg_mode[1:0]               0=auto prefer A, 1=force A, 2=force B, 3=auto prefer B
//   sync_ok_x, pll_locked_x     health inputs of source x (a/b)
//   time_x[63:0], time_upd_x    time value and single-cycle update strobe of source x
//   ntp_time[63:0]              time of the active source, registered
//   ntp_time_upd                one-cycle strobe accompanying each ntp_time update
//   time_valid                  high while a source is active
//   active_sel                  0=A, 1=B; holds its last value while no source is active
//   qualified[1:0]              {qual_b, qual_a}
//   switch_count                saturating count of entries into an active state

module ntp_clock_select #(
    parameter int HOLDOFF_CYCLES = 1000,
    parameter int CNT_WIDTH      = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [1:0]           cfg_mode,
    input  logic                 sync_ok_a,
    input  logic                 pll_locked_a,
    input  logic [63:0]          time_a,
    input  logic                 time_upd_a,
    input  logic                 sync_ok_b,
    input  logic                 pll_locked_b,
    input  logic [63:0]          time_b,
    input  logic                 time_upd_b,
    output logic [63:0]          ntp_time,
    output logic                 ntp_time_upd,
    output logic                 time_valid,
    output logic                 active_sel,
    output logic [1:0]           qualified,
    output logic [CNT_WIDTH-1:0] switch_count
);

    localparam logic [15:0] HOLDOFF = 16'(HOLDOFF_CYCLES);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

    typedef enum logic [1:0] {
        NONE  = 2'd0,
        USE_A = 2'd1,
        USE_B = 2'd2
    } state_t;

    state_t      state;
    state_t      state_next;
    logic        entering;

    logic        healthy_a;
    logic        healthy_b;
    logic [15:0] qual_cnt_a;
    logic [15:0] qual_cnt_b;
    logic        qual_a;
    logic        qual_b;

    assign healthy_a = sync_ok_a & pll_locked_a;
    assign healthy_b = sync_ok_b & pll_locked_b;
    assign qualified = {qual_b, qual_a};

    // Holdoff qualification: qual rises on the edge the counter reaches
    // HOLDOFF, i.e. HOLDOFF edges after health is first sampled high. Any
    // unhealthy sample restarts the count.
    always_ff @(posedge clk) begin
        if (reset) begin
            qual_cnt_a <= '0;
            qual_a     <= 1'b0;
        end else if (!healthy_a) begin
            qual_cnt_a <= '0;
            qual_a     <= 1'b0;
        end else if (qual_cnt_a < HOLDOFF) begin
            qual_cnt_a <= qual_cnt_a + 16'd1;
            if (qual_cnt_a + 16'd1 == HOLDOFF) begin
                qual_a <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            qual_cnt_b <= '0;
            qual_b     <= 1'b0;
        end else if (!healthy_b) begin
            qual_cnt_b <= '0;
            qual_b     <= 1'b0;
        end else if (qual_cnt_b < HOLDOFF) begin
            qual_cnt_b <= qual_cnt_b + 16'd1;
            if (qual_cnt_b + 16'd1 == HOLDOFF) begin
                qual_b <= 1'b1;
            end
        end
    end

    // Selection is purely a function of the qualified flags and mode; the
    // holdoff already debounces, so reverting to the preferred source is
    // immediate.
    always_comb begin
        state_next = NONE;
        case (cfg_mode)
            2'd0: begin
                if (qual_a)      state_next = USE_A;
                else if (qual_b) state_next = USE_B;
            end
            2'd1: begin
                if (qual_a)      state_next = USE_A;
            end
            2'd2: begin
                if (qual_b)      state_next = USE_B;
            end
            default: begin
                if (qual_b)      state_next = USE_B;
                else if (qual_a) state_next = USE_A;
            end
        endcase
        entering = (state_next != NONE) && (state_next != state);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= NONE;
            active_sel   <= 1'b0;
            switch_count <= '0;
        end else begin
            state <= state_next;
            if (state_next != NONE) begin
                active_sel <= (state_next == USE_B);
            end
            if (entering && (switch_count != CNT_MAX)) begin
                switch_count <= switch_count + 1'b1;
            end
        end
    end

    assign time_valid = (state != NONE);

    // The datapath follows the registered state, so a strobe on the switch
    // edge is still taken from the old source and sources never mix.
    always_ff @(posedge clk) begin
        if (reset) begin
            ntp_time     <= '0;
            ntp_time_upd <= 1'b0;
        end else if ((state == USE_A) && time_upd_a) begin
            ntp_time     <= time_a;
            ntp_time_upd <= 1'b1;
        end else if ((state == USE_B) && time_upd_b) begin
            ntp_time     <= time_b;
            ntp_time_upd <= 1'b1;
        end else begin
            ntp_time_upd <= 1'b0;
        end
    end

endmodule

// File: doc/ntp_clock_select.md
Name: ntp_clock_select

Overview:
- Controller that picks one of the two NTP clock instances (A/B) as the active time source for the NTP datapath.
- Qualifies each source's health (SYNC_OK and PLL lock) with a holdoff counter and runs a failover/revert state machine under a configurable mode.
- Forwards only the selected source's time and update strobe to the packet engine.
- Sits between the ntp_clock_top pair and the NTP responder; mode comes from a control register.

Parameters:
- HOLDOFF_CYCLES, 1000: consecutive healthy cycles needed before a source is qualified. Legal range 1..65535.
- CNT_WIDTH, 16: width of the switch_count output.

Ports:
- clk  in  1  block clock; all inputs are synchronous to it.
- reset  in  1  synchronous, active-high reset.
- cfg_mode  in  2  0=auto prefer A, 1=force A, 2=force B, 3=auto prefer B.
- sync_ok_a  in  1  SYNC_OK from clock A.
- pll_locked_a  in  1  PLL lock from clock A.
- time_a  in  64  NTP time from clock A.
- time_upd_a  in  1  single-cycle update strobe for time_a.
- sync_ok_b  in  1  SYNC_OK from clock B.
- pll_locked_b  in  1  PLL lock from clock B.
- time_b  in  64  NTP time from clock B.
- time_upd_b  in  1  single-cycle update strobe for time_b.
- ntp_time  out  64  selected NTP time (registered).
- ntp_time_upd  out  1  update strobe for ntp_time.
- time_valid  out  1  1 while a source is active.
- active_sel  out  1  0=A, 1=B; meaningful only when time_valid=1.
- qualified  out  2  {qual_b, qual_a} qualification flags.
- switch_count  out  CNT_WIDTH  number of entries into an active state, saturating.

Behaviour:
- Reset values: ntp_time=0, ntp_time_upd=0, time_valid=0, active_sel=0, qualified=0, switch_count=0. Reset also clears both qual counters and puts the FSM in NONE.
- Health: healthy_x = sync_ok_x & pll_locked_x, sampled every clk.
- Qualification, per source:
  - If healthy_x=0: qual_cnt_x <= 0 and qual_x <= 0. Loss is seen one cycle later.
  - If healthy_x=1 and qual_cnt_x < HOLDOFF_CYCLES: qual_cnt_x increments.
  - qual_x <= 1 on the edge where qual_cnt_x becomes HOLDOFF_CYCLES. So qual_x rises HOLDOFF_CYCLES edges after healthy_x is first sampled high.
  - The counter saturates at HOLDOFF_CYCLES.
  - A glitch of one low cycle restarts the count from 0.
- FSM states: NONE, USE_A, USE_B. The next state is evaluated each cycle from qual_a, qual_b and cfg_mode.
  - Force A (mode 1): USE_A if qual_a, else NONE. Force B (mode 2) is symmetric.
  - Auto prefer A (mode 0): USE_A if qual_a; else USE_B if qual_b; else NONE. Revert to A is immediate once qual_a=1, since the holdoff is already applied.
  - Auto prefer B (mode 3) is symmetric.
  - If both sources qualify in the same cycle, the preferred source wins.
  - A cfg_mode change takes effect on the next edge; no holdoff is re-applied.
- Outputs:
  - time_valid = (state != NONE).
  - active_sel = (state == USE_B). In NONE, active_sel holds its last value.
- Switching counter: switch_count increments on every edge where the state enters USE_A or USE_B from a different state. This includes NONE->USE_x and USE_A<->USE_B. It saturates at all-ones.
- Datapath:
  - Uses the registered state (the current state, not next).
  - When state=USE_A and time_upd_a=1: ntp_time <= time_a and ntp_time_upd <= 1. The same applies for B.
  - Otherwise ntp_time_upd <= 0 and ntp_time holds.
  - Latency is 1 cycle from strobe to output.
  - Strobes from the non-selected source are ignored.
  - In NONE, ntp_time holds its last value and no strobe is produced.
- Switch cycle: the new state applies from the edge after it is registered. A strobe arriving on the switch edge is sampled against the old state. The output never carries a mix of sources.
- Reset mid-operation: everything returns to reset values on the next edge. Qualification restarts from 0 for both sources.

Test Plan (HOLDOFF_CYCLES=8):
1. Mode 0, A healthy from cycle 10 → qual_a=1 at cycle 18, time_valid=1 and active_sel=0 at cycle 19, switch_count=1. A strobe with time_a=0x0000_0001_8000_0000 → ntp_time equals it one cycle later, with ntp_time_upd high for one cycle.
2. Failover: mode 0 with A and B both qualified, active A. Drop sync_ok_a → qual_a=0 next edge, state USE_B one edge after, switch_count increments by 1. Strobes on time_upd_a are not forwarded after that; time_b strobes are.
3. Revert and debounce: from scenario 2, restore A health but drop it low for one cycle at count 5 → no switch. Then hold it 8 cycles → revert to USE_A, switch_count increments by 1.
4. Forced mode: set cfg_mode=2 while B is unqualified and A is active → NONE next edge, time_valid=0, ntp_time holds its last value. Qualify B → USE_B.
5. Simultaneous qualification: mode 3, A and B healthy in the same cycle → USE_B selected and switch_count=1. Assert reset mid-run → all outputs 0 next edge, and requalification takes 8 cycles.
6. Saturation: CNT_WIDTH=4, toggle cfg_mode between 1 and 2 with both sources qualified 20 times → switch_count stays at 15.
